// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display back end: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the digit scan index encoding.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] AN_OFF   = 3'b111;

  typedef enum logic [1:0] {
    DIG_TENTHS  = 2'd0,
    DIG_SECONDS = 2'd1,
    DIG_MINUTES = 2'd2,
    DIG_INVALID = 2'd3
  } dig_idx_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// show a dash so a corrupted digit is visible on the display.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_seg_scan.sv
// Time-multiplexed 3-digit common-anode display driver with lap snapshot,
// flash blanking and leading-zero suppression; an/seg/dp are registered together.
module stopwatch_seg_scan
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int FLASH_DIV   = 25000000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] minutes_bcd,
  input  logic [3:0] seconds_bcd,
  input  logic [3:0] tenths_bcd,
  input  logic       flash,
  input  logic       lap_hold,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
  localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_TC = FW'(FLASH_DIV - 1);

  logic [11:0]   snap_q, snap_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  dig_idx_e      idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    dig;
  logic [6:0]    dec_seg;

  // Snapshot follows the inputs unless a lap time is being held.
  always_comb begin
    snap_d = snap_q;
    if (!lap_hold) snap_d = {minutes_bcd, seconds_bcd, tenths_bcd};
  end

  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == R_TC) begin
      rcnt_d = '0;
      case (idx_q)
        DIG_TENTHS:  idx_d = DIG_SECONDS;
        DIG_SECONDS: idx_d = DIG_MINUTES;
        default:     idx_d = DIG_TENTHS;
      endcase
    end
    if (idx_q == DIG_INVALID) idx_d = DIG_TENTHS;
  end

  // Flash phase restarts visible whenever flash is low.
  always_comb begin
    fcnt_d  = '0;
    phase_d = 1'b1;
    if (flash) begin
      phase_d = phase_q;
      if (fcnt_q == F_TC) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dig = 4'h0;
    case (idx_q)
      DIG_TENTHS:  dig = snap_q[3:0];
      DIG_SECONDS: dig = snap_q[7:4];
      DIG_MINUTES: dig = snap_q[11:8];
      default:     dig = 4'h0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (dig),
    .seg (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = dec_seg;
    dp_d  = 1'b1;
    case (idx_q)
      DIG_TENTHS:  an_d = 3'b110;
      DIG_SECONDS: begin
        an_d = 3'b101;
        dp_d = 1'b0;
      end
      DIG_MINUTES: begin
        an_d = 3'b011;
        if (BLANK_LZ && (snap_q[11:8] == 4'h0)) seg_d = SEG_OFF;
      end
      default:     seg_d = SEG_OFF;
    endcase
    if (!phase_q) begin
      an_d = AN_OFF;
      dp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      rcnt_q  <= '0;
      idx_q   <= DIG_TENTHS;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      snap_q  <= snap_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
// Bench for stopwatch_seg_scan: directed scenarios followed by random traffic,
// each cycle compared against a cycle-position reference model.
module tb_stopwatch_seg_scan;

  localparam int RD = 4;
  localparam int FD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] minutes_bcd, seconds_bcd, tenths_bcd;
  logic       flash, lap_hold;
  logic [2:0] an, an0;
  logic [6:0] seg, seg0;
  logic       dp, dp0;

  int ncmp = 0;
  int nfail = 0;

  logic [11:0] m_snap;
  int          m_scan;
  int          m_fn;

  always #5 clk = ~clk;

  stopwatch_seg_scan #(.REFRESH_DIV(RD), .FLASH_DIV(FD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd),
    .tenths_bcd(tenths_bcd), .flash(flash), .lap_hold(lap_hold),
    .an(an), .seg(seg), .dp(dp)
  );

  stopwatch_seg_scan #(.REFRESH_DIV(RD), .FLASH_DIV(FD), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd),
    .tenths_bcd(tenths_bcd), .flash(flash), .lap_hold(lap_hold),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: predict the registered outputs from the pre-edge model state,
  // advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int         idx;
    bit         vis, rst_now;
    logic [3:0] d;
    logic [2:0] ea;
    logic [6:0] es, es0;
    logic       ed;
    idx = m_scan / RD;
    vis = ((m_fn / FD) % 2) == 0;
    case (idx)
      0:       d = m_snap[3:0];
      1:       d = m_snap[7:4];
      default: d = m_snap[11:8];
    endcase
    ea  = vis ? ~(3'b001 << idx) : 3'b111;
    ed  = (vis && idx == 1) ? 1'b0 : 1'b1;
    es  = ref_seg(d);
    es0 = es;
    if (idx == 2 && m_snap[11:8] == 4'h0) es = 7'b1111111;
    rst_now = reset;
    if (rst_now) begin
      ea = 3'b111; es = 7'b1111111; es0 = 7'b1111111; ed = 1'b1;
      m_snap = 12'h000; m_scan = 0; m_fn = 0;
    end else begin
      if (!lap_hold) m_snap = {minutes_bcd, seconds_bcd, tenths_bcd};
      m_scan = (m_scan + 1) % (3 * RD);
      m_fn   = flash ? m_fn + 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("an", {4'b0, an}, {4'b0, ea});
    chk("dp", {6'b0, dp}, {6'b0, ed});
    chk("an_nolz", {4'b0, an0}, {4'b0, ea});
    if (rst_now || vis) begin
      chk("seg", seg, es);
      chk("seg_nolz", seg0, es0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(input logic [3:0] m, input logic [3:0] s, input logic [3:0] t);
    minutes_bcd = m; seconds_bcd = s; tenths_bcd = t;
  endtask

  initial begin
    m_snap = 12'h000; m_scan = 0; m_fn = 0;
    reset = 1'b1; flash = 1'b0; lap_hold = 1'b0;
    set_in(4'd3, 4'd7, 4'd5);
    @(negedge clk);
    steps(2);

    reset = 1'b0;
    steps(6 * RD);

    set_in(4'd0, 4'd7, 4'd5);
    steps(6 * RD);

    set_in(4'd1, 4'd2, 4'hC);
    steps(3 * RD);

    flash = 1'b1;
    steps(5 * FD);
    flash = 1'b0;
    steps(3 * RD);
    flash = 1'b1;
    steps(FD + 3);
    flash = 1'b0;
    steps(3 * RD);

    set_in(4'd2, 4'd5, 4'd6);
    steps(3);
    lap_hold = 1'b1;
    step();
    set_in(4'd2, 4'd0, 4'd0);
    steps(6 * RD);
    lap_hold = 1'b0;
    steps(6 * RD);

    for (int i = 0; i < 3 * RD && (m_scan / RD) != 2; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(3 * RD);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) minutes_bcd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) seconds_bcd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tenths_bcd  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) flash = ~flash;
      if ($urandom_range(0, 19) == 0) lap_hold = ~lap_hold;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
